sample0_mac_acc: RTL and testbench
==================================

SAMPLE0_MAC_ACC -- requirements
Module: sample0_mac_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 15, signed product width from the upstream multiplier.
REQ-002 SHALL have parameter ACC_WIDTH, default 24, signed accumulator width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 15, signed result width.
REQ-004 SHALL have parameter CNT_WIDTH, default 8, term-counter width.
REQ-005 SHALL have port clk, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port ce, input, 1: clock enable; all state frozen while low.
REQ-008 SHALL have port din, input, DIN_WIDTH: signed product (multiplier dout).
REQ-009 SHALL have port din_valid, input, 1: din qualifier, already aligned to multiplier latency.
REQ-010 SHALL have port din_last, input, 1: marks the final term of a dot product.
REQ-011 SHALL have port din_ready, output, 1: block accepts a term this cycle.
REQ-012 SHALL have port dout, output, DOUT_WIDTH: signed dot-product result.
REQ-013 SHALL have port dout_valid, output, 1: dout holds a result.
REQ-014 SHALL have port dout_ready, input, 1: consumer accepts dout.
REQ-015 SHALL have port ovf, output, 1: sticky flag; result clipped or term count wrapped.

Function
REQ-016 SHALL implement FSM IDLE, ACCUM, HOLD; a term is accepted when ce & din_valid & din_ready.
REQ-017 SHALL drive din_ready high in IDLE and ACCUM, low in HOLD.
REQ-018 SHALL, in IDLE, on accepted non-last term load acc = sext(din), cnt = 1, go to ACCUM.
REQ-019 SHALL, in ACCUM, on accepted non-last term set acc = acc + sext(din), cnt = cnt + 1.
REQ-020 SHALL, on accepted last term (IDLE or ACCUM), register the final sum into dout, assert dout_valid next cycle, go to HOLD; a single-term product is legal.
REQ-021 SHALL hold dout and dout_valid stable in HOLD until ce & dout_ready; then deassert dout_valid, clear acc and cnt, return to IDLE.
REQ-022 SHALL sustain no overlap: the next product's first term is accepted no earlier than the cycle after the handshake.
REQ-023 SHALL, when cnt wraps from all-ones to zero, set ovf and keep accumulating.
REQ-024 SHALL keep acc wrapping modulo 2^ACC_WIDTH internally; only the dout conversion saturates or truncates.
REQ-025 SHALL freeze FSM, acc, cnt, dout, dout_valid, ovf while ce is low; dout_ready is ignored while ce is low.
REQ-026 SHALL clear ovf only on reset.

Reset
REQ-027 SHALL, on reset high at a clock edge, set state IDLE, acc 0, cnt 0, dout 0, dout_valid 0, ovf 0, regardless of ce.
REQ-028 SHALL abandon any partial sum or held result on reset; din_ready is 1 in the first cycle after reset.

Configuration
REQ-029 SHALL, with SAMPLE0_MAC_ACC_SAT_EN defined, clip the final sum to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1] and set ovf when clipping occurs.
REQ-030 SHALL, without SAMPLE0_MAC_ACC_SAT_EN, output the low DOUT_WIDTH bits of the final sum, and never set ovf from clipping.

Structure
REQ-031 SHALL place the FSM state enum and default width constants in shared package sample0_pkg.
REQ-032 SHALL implement the sum-to-dout conversion in sub-module sample0_mac_acc_sat, a combinational block containing the SAMPLE0_MAC_ACC_SAT_EN switch.

Verification
REQ-033 SHALL cover: terms 100, -20, 5 (last on 5), dout_ready=1 -> dout=85, dout_valid one cycle after the last term, for one cycle.
REQ-034 SHALL cover: single term 7 with last, dout_ready=0 for 5 cycles -> dout=7 held, din_ready=0 throughout, release then IDLE.
REQ-035 SHALL cover: three terms 16383 (last on third), SAT_EN defined -> dout=16383, ovf=1; undefined -> dout=16381 (low 15 bits of 49149), ovf=0.
REQ-036 SHALL cover: ce low for 3 cycles mid-stream with din_valid=1 -> no terms accepted, final sum equals the ce-always-high sum.
REQ-037 SHALL cover: reset asserted in ACCUM after terms 50, 60 -> next product 9 (last) yields dout=9.
REQ-038 SHALL cover: 257 terms of 1 with CNT_WIDTH=8 -> ovf=1 after the 256th term, dout=257 saturated/truncated per macro.

Source files
------------

// File: rtl/sample0_pkg.sv
// Shared definitions for the sample0 MAC accumulator: FSM state encoding
// and the default widths used by the top-level parameters.
package sample0_pkg;

  localparam int DIN_WIDTH_DEF  = 15;
  localparam int ACC_WIDTH_DEF  = 24;
  localparam int DOUT_WIDTH_DEF = 15;
  localparam int CNT_WIDTH_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/sample0_mac_acc_sat.sv
// Combinational conversion of the accumulator sum to the output width.
// Build option SAMPLE0_MAC_ACC_SAT_EN: when defined, the sum is clipped to
// the signed DOUT_WIDTH range and clip_o flags it; otherwise the low
// DOUT_WIDTH bits are passed through and clip_o stays low.
module sample0_mac_acc_sat #(
  parameter int ACC_WIDTH  = 24,
  parameter int DOUT_WIDTH = 15
) (
  input  logic signed [ACC_WIDTH-1:0]  sum_i,
  output logic signed [DOUT_WIDTH-1:0] dout_o,
  output logic                         clip_o
);

`ifdef SAMPLE0_MAC_ACC_SAT_EN
  localparam logic [DOUT_WIDTH-1:0] MAX_VAL = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] MIN_VAL = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  // The sum fits when every bit from the output sign bit upward agrees.
  logic [ACC_WIDTH-DOUT_WIDTH:0] top_bits;
  assign top_bits = sum_i[ACC_WIDTH-1:DOUT_WIDTH-1];

  // Clip toward the sign of the sum whenever the upper bits disagree.
  always_comb begin
    dout_o = sum_i[DOUT_WIDTH-1:0];
    clip_o = 1'b0;
    if (!((&top_bits) || (~|top_bits))) begin
      clip_o = 1'b1;
      dout_o = sum_i[ACC_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end
  end
`else
  // Plain truncation; the discarded upper bits are deliberately unused.
  logic unused_hi;
  assign unused_hi = ^sum_i[ACC_WIDTH-1:DOUT_WIDTH];
  assign dout_o    = sum_i[DOUT_WIDTH-1:0];
  assign clip_o    = 1'b0;
`endif

endmodule

// File: rtl/sample0_mac_acc.sv
// Dot-product accumulator behind a multiplier. Terms are summed until the
// one flagged last; the converted result is then held until the consumer
// takes it. Conversion mode is selected by SAMPLE0_MAC_ACC_SAT_EN (see
// sample0_mac_acc_sat). ovf is sticky until reset.
module sample0_mac_acc
  import sample0_pkg::*;
#(
  parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic signed [DIN_WIDTH-1:0]  din,
  input  logic                         din_valid,
  input  logic                         din_last,
  output logic                         din_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         ovf
);

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;
  logic                         ovf_q, ovf_d;

  logic signed [ACC_WIDTH-1:0]  din_ext;
  logic signed [ACC_WIDTH-1:0]  sum_term;
  logic [CNT_WIDTH-1:0]         cnt_inc;
  logic                         cnt_wrap;
  logic signed [DOUT_WIDTH-1:0] conv_dout;
  logic                         conv_clip;

  assign din_ext  = {{(ACC_WIDTH-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  // The first term of a product replaces the accumulator rather than adding.
  assign sum_term = (state_q == ST_IDLE) ? din_ext : acc_q + din_ext;
  assign cnt_inc  = (state_q == ST_IDLE) ? CNT_WIDTH'(1) : cnt_q + CNT_WIDTH'(1);
  assign cnt_wrap = (state_q == ST_ACCUM) && (&cnt_q);

  sample0_mac_acc_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .DOUT_WIDTH(DOUT_WIDTH)
  ) u_sat (
    .sum_i (sum_term),
    .dout_o(conv_dout),
    .clip_o(conv_clip)
  );

  // Next-state logic: accept terms outside HOLD, release on consumer handshake.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    ovf_d        = ovf_q;
    if (ce) begin
      case (state_q)
        ST_IDLE, ST_ACCUM: begin
          if (din_valid) begin
            acc_d = sum_term;
            cnt_d = cnt_inc;
            if (cnt_wrap) ovf_d = 1'b1;
            if (din_last) begin
              dout_d       = conv_dout;
              dout_valid_d = 1'b1;
              if (conv_clip) ovf_d = 1'b1;
              state_d      = ST_HOLD;
            end else begin
              state_d = ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (dout_ready) begin
            dout_valid_d = 1'b0;
            acc_d        = '0;
            cnt_d        = '0;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers; reset wins over ce, ce low holds everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign din_ready  = (state_q != ST_HOLD);
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_sample0_mac_acc.sv
// Scoreboard bench for sample0_mac_acc: directed products push their
// hand-computed result into a queue; the monitor pops and compares on each
// output handshake. Inline checks cover latency, holding and reset.
module tb_sample0_mac_acc;

  logic               clk = 1'b0;
  logic               reset;
  logic               ce;
  logic signed [14:0] din;
  logic               din_valid;
  logic               din_last;
  logic               din_ready;
  logic signed [14:0] dout;
  logic               dout_valid;
  logic               dout_ready;
  logic               ovf;

  typedef struct {
    int name_id;
    int d;
    bit o;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  sample0_mac_acc dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .din       (din),
    .din_valid (din_valid),
    .din_last  (din_last),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .ovf       (ovf)
  );

  task automatic check(input string name, input int act, input int req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every accepted output is compared against the queue head.
  always @(negedge clk) begin
    if (!reset && ce && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_result: got dout=%0d, expected no result", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] product %0d: dout=%0d ovf=%0b (expected %0d / %0b)",
                 e.name_id, dout, ovf, e.d, e.o);
        check($sformatf("p%0d_dout", e.name_id), int'(dout), e.d);
        check($sformatf("p%0d_ovf", e.name_id), int'(ovf), int'(e.o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic term(input int v, input bit last);
    din       = 15'(v);
    din_valid = 1'b1;
    din_last  = last;
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input int id, input int d, input bit o);
    exp_t e;
    e.name_id = id;
    e.d       = d;
    e.o       = o;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    ce         = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_din_ready", int'(din_ready), 1);

    // Product 1: 100 - 20 + 5 = 85, valid for exactly one cycle
    push(1, 85, 1'b0);
    term(100, 1'b0);
    term(-20, 1'b0);
    term(5, 1'b1);
    check("p1_valid_next_cycle", int'(dout_valid), 1);
    check("p1_din_ready_hold", int'(din_ready), 0);
    tick();
    check("p1_valid_one_cycle", int'(dout_valid), 0);
    check("p1_din_ready_idle", int'(din_ready), 1);

    // Product 2: single term 7, consumer stalls 5 cycles, upstream keeps offering
    dout_ready = 1'b0;
    push(2, 7, 1'b0);
    term(7, 1'b1);
    din       = 15'sd99;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("p2_hold_valid", int'(dout_valid), 1);
      check("p2_hold_dout", int'(dout), 7);
      check("p2_hold_din_ready", int'(din_ready), 0);
      tick();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    tick();
    check("p2_release_valid", int'(dout_valid), 0);
    check("p2_release_din_ready", int'(din_ready), 1);

    // Product 3: 3 x 16383 = 49149
    do_reset();
    push(3,
`ifdef SAMPLE0_MAC_ACC_SAT_EN
         16383, 1'b1
`else
         16381, 1'b0
`endif
    );
    term(16383, 1'b0);
    term(16383, 1'b0);
    term(16383, 1'b1);
    tick();

    // Product 4: ce low mid-stream and during HOLD; 10 + 20 + 30 = 60
    do_reset();
    push(4, 60, 1'b0);
    term(10, 1'b0);
    ce        = 1'b0;
    din       = 15'sd1000;
    din_valid = 1'b1;
    din_last  = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
    ce        = 1'b1;
    check("p4_ce_low_no_result", int'(dout_valid), 0);
    term(20, 1'b0);
    term(30, 1'b1);
    ce = 1'b0;
    tick();
    tick();
    check("p4_ce_low_hold_valid", int'(dout_valid), 1);
    check("p4_ce_low_hold_dout", int'(dout), 60);
    ce = 1'b1;
    tick();
    check("p4_release_valid", int'(dout_valid), 0);

    // Product 5: reset in ACCUM discards 50 + 60, then 9 alone
    term(50, 1'b0);
    term(60, 1'b0);
    do_reset();
    check("p5_rst_din_ready", int'(din_ready), 1);
    check("p5_rst_dout_valid", int'(dout_valid), 0);
    check("p5_rst_dout", int'(dout), 0);
    push(5, 9, 1'b0);
    term(9, 1'b1);
    tick();

    // Product 6: 257 ones, term counter wraps at the 256th
    do_reset();
    push(6, 257, 1'b1);
    for (int i = 0; i < 255; i++) term(1, 1'b0);
    check("p6_ovf_before_wrap", int'(ovf), 0);
    term(1, 1'b0);
    check("p6_ovf_after_wrap", int'(ovf), 1);
    term(1, 1'b1);
    tick();
    check("p6_ovf_sticky", int'(ovf), 1);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
